winner_detect: RTL and testbench
================================

WINNER_DETECT -- requirements
Module: winner_detect

Interface
REQ-001 The block SHALL provide parameter ROWS, default 6, meaning the number of board rows, with row 0 at the bottom.
REQ-002 The block SHALL provide parameter COLS, default 7, meaning the number of board columns, with column 0 at the left.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port board, input, 2*ROWS*COLS bits: one cell per index i=r*COLS+c, held in bits [2i+1:2i]. Codes: 00 empty, 01 J1, 10 J2, 11 invalid.
REQ-006 Port start, input, 1 bit: single-cycle request to evaluate board.
REQ-007 Port busy, output, 1 bit: high while a scan is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking the cycle in which a new ganador value is valid.
REQ-009 Port ganador, output, 2 bits: 00 none, 01 J1, 10 J2, 11 draw. This is the encoding consumed by the finish-screen renderer.

Function
REQ-010 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-011 In IDLE, start=1 SHALL capture board into an internal snapshot, set busy=1 and enter SCAN. Call the capture edge cycle T.
REQ-012 Changes on board after capture SHALL NOT affect the scan in progress.
REQ-013 SCAN SHALL evaluate one anchor k=r*COLS+c per cycle, in increasing k. Anchor k is evaluated in cycle T+1+k.
REQ-014 Each anchor SHALL be tested in four directions:
- horizontal, when c+3<COLS
- vertical, when r+3<ROWS
- up-right diagonal, when r+3<ROWS and c+3<COLS
- up-left diagonal, when r+3<ROWS and c>=3
REQ-015 A line SHALL count as a hit only when all 4 cells hold the same code and that code is 01 or 10. Code 11 SHALL be treated as empty.
REQ-016 On the first hit, the FSM SHALL latch that player and go to DONE. No later anchors SHALL be evaluated.
REQ-017 If one anchor has hits for both players, 01 SHALL win.
REQ-018 If the last anchor (ROWS*COLS-1) is evaluated with no hit, the FSM SHALL go to DONE with the result selected per REQ-025/REQ-026.
REQ-019 DONE SHALL last exactly one cycle. In it: done=1, ganador takes the new value, busy=0. The FSM SHALL then return to IDLE.
REQ-020 Latency SHALL be as follows:
- hit at anchor k: done at cycle T+2+k
- no hit: done at cycle T+1+ROWS*COLS (T+43 with default parameters)
REQ-021 ganador SHALL hold its last value between DONE cycles, including throughout a scan.
REQ-022 start SHALL be ignored while busy=1 and while in DONE.
REQ-023 done and ganador SHALL be driven directly from registers.
REQ-024 The anchor counter SHALL be sized ceil(log2(ROWS*COLS)) bits and SHALL NOT wrap. The FSM SHALL leave SCAN at the last anchor.

Configuration
REQ-025 With macro WINNER_DRAW_DETECT_EN defined, a scan with no hit SHALL report 11 if every snapshot cell is 01 or 10, and 00 otherwise.
REQ-026 With WINNER_DRAW_DETECT_EN undefined, a scan with no hit SHALL always report 00, and no fullness logic SHALL be synthesized.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, ganador=00, anchor counter=0, snapshot=0.
REQ-028 A reset asserted mid-scan SHALL abort the scan. No done pulse SHALL follow.
REQ-029 After rst_n deasserts, the first accepted start SHALL behave exactly as in REQ-011.

Verification
REQ-030 Cells (0,0)-(0,3)=01, others 00; start at T -> done=1 at T+2, ganador=01, busy low at T+2.
REQ-031 Cells (2,6),(3,6),(4,6),(5,6)=10 -> anchor 20; done at T+22, ganador=10.
REQ-032 Up-left diagonal (0,3),(1,2),(2,1),(3,0)=01 -> done at T+5, ganador=01. Same board with (0,3)=11 and no other hit -> done at T+43, ganador=00.
REQ-033 Full board, no 4-in-line, alternating codes:
- with WINNER_DRAW_DETECT_EN: done at T+43, ganador=11
- without it: ganador=00
REQ-034 Previous ganador=01; start accepted, then board changed and start pulsed at T+5 -> pulse ignored, ganador stays 01 until the single done at T+43, result computed from the snapshot.
REQ-035 rst_n low at T+10 mid-scan -> busy=0, ganador=00 immediately, and no done pulse for the next 50 cycles.

Source files
------------

// File: rtl/winner_detect.sv
// Four-in-a-row winner detector: snapshots a board, scans one anchor per cycle, reports the winner.
// Optional macro WINNER_DRAW_DETECT_EN: report 11 (draw) when a hit-free board is completely filled.
module winner_detect #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*ROWS*COLS-1:0]   board,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               ganador
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q;
  logic [2*N-1:0]  snap_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   row_q;
  logic [KW-1:0]   col_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      gan_q;

  logic [1:0]      own_h, own_v, own_ur, own_ul;
  logic            hit_j1, hit_j2;
  logic            last_anchor;
  logic [1:0]      nohit_res;
  int              ar, ac;

  function automatic logic [1:0] cell_at(input logic [2*N-1:0] s, input int r, input int c);
    logic [1:0]    v;
    logic [IW-1:0] idx;
    v = 2'b00;
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      idx = IW'(2 * (r * COLS + c));
      v   = s[idx +: 2];
    end
    return v;
  endfunction

  // Returns the player owning all four cells of the line, or 00; code 11 never owns a line.
  function automatic logic [1:0] line_owner(input logic [2*N-1:0] s, input int r, input int c,
                                            input int dr, input int dc);
    logic [1:0] first;
    logic       same;
    first = cell_at(s, r, c);
    same  = (first == 2'b01) || (first == 2'b10);
    for (int j = 1; j < 4; j++) begin
      if (cell_at(s, r + j * dr, c + j * dc) != first) same = 1'b0;
    end
    return same ? first : 2'b00;
  endfunction

  always_comb begin
    ar     = int'(row_q);
    ac     = int'(col_q);
    own_h  = (ac + 3 < COLS)                 ? line_owner(snap_q, ar, ac, 0,  1) : 2'b00;
    own_v  = (ar + 3 < ROWS)                 ? line_owner(snap_q, ar, ac, 1,  0) : 2'b00;
    own_ur = (ar + 3 < ROWS && ac + 3 < COLS) ? line_owner(snap_q, ar, ac, 1,  1) : 2'b00;
    own_ul = (ar + 3 < ROWS && ac >= 3)      ? line_owner(snap_q, ar, ac, 1, -1) : 2'b00;
    hit_j1 = (own_h == 2'b01) || (own_v == 2'b01) || (own_ur == 2'b01) || (own_ul == 2'b01);
    hit_j2 = (own_h == 2'b10) || (own_v == 2'b10) || (own_ur == 2'b10) || (own_ul == 2'b10);
  end

  assign last_anchor = (cnt_q == CW'(N - 1));

`ifdef WINNER_DRAW_DETECT_EN
  logic board_full;
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (snap_q[IW'(2 * i) +: 2] == 2'b00 || snap_q[IW'(2 * i) +: 2] == 2'b11) board_full = 1'b0;
    end
  end
  assign nohit_res = board_full ? 2'b11 : 2'b00;
`else
  assign nohit_res = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gan_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            snap_q  <= board;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit_j1 || hit_j2) begin
            gan_q   <= hit_j1 ? 2'b01 : 2'b10;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (last_anchor) begin
            gan_q   <= nohit_res;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (col_q == KW'(COLS - 1)) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + KW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ganador = gan_q;

endmodule

// File: tb/tb_winner_detect.sv
// Bench for winner_detect: vector table plus scoreboard of {due cycle, winner} checked on every done pulse.
module tb_winner_detect;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int N    = ROWS * COLS;
  localparam int BW   = 2 * N;
`ifdef WINNER_DRAW_DETECT_EN
  localparam logic [1:0] DRAW_RES = 2'b11;
`else
  localparam logic [1:0] DRAW_RES = 2'b00;
`endif

  typedef struct {
    logic [BW-1:0] b;
    int            lat;
    logic [1:0]    gan;
  } vec_t;

  typedef struct {
    int         due;
    logic [1:0] gan;
  } exp_t;

  logic          clk, rst_n, start, busy, done;
  logic [BW-1:0] board;
  logic [1:0]    ganador;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [1:0] held = 2'b00;
  exp_t q[$];
  vec_t vecs[11];

  winner_detect #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .board(board), .start(start),
    .busy(busy), .done(done), .ganador(ganador)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                        input logic [1:0] v);
    logic [BW-1:0] o;
    o = b;
    o[2 * (r * COLS + c) +: 2] = v;
    return o;
  endfunction

  function automatic logic [BW-1:0] draw_board();
    logic [BW-1:0] o;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        o = put(o, r, c, (((c / 2) + r) % 2 == 1) ? 2'b10 : 2'b01);
    return o;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 2'b00;
    end else if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.due);
        check("ganador", int'(ganador), int'(e.gan));
        check("busy_at_done", int'(busy), 0);
      end
      held = ganador;
    end else if (ganador !== held) begin
      check("ganador_hold", int'(ganador), int'(held));
      held = ganador;
    end
  end

  task automatic launch(input logic [BW-1:0] b, input int lat, input logic [1:0] gan);
    exp_t e;
    @(posedge clk); #1;
    board = b;
    start = 1'b1;
    e.due = cyc + lat;
    e.gan = gan;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_capture", int'(busy), 1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  initial begin
    logic [BW-1:0] b;
    int t;

    b = '0;
    vecs[0] = '{put(put(put(put(b, 0, 0, 2'b01), 0, 1, 2'b01), 0, 2, 2'b01), 0, 3, 2'b01), 2, 2'b01};
    vecs[1] = '{put(put(put(put(b, 2, 6, 2'b10), 3, 6, 2'b10), 4, 6, 2'b10), 5, 6, 2'b10), 22, 2'b10};
    vecs[2] = '{put(put(put(put(b, 0, 3, 2'b01), 1, 2, 2'b01), 2, 1, 2'b01), 3, 0, 2'b01), 5, 2'b01};
    vecs[3] = '{put(put(put(put(b, 0, 3, 2'b11), 1, 2, 2'b01), 2, 1, 2'b01), 3, 0, 2'b01), 43, 2'b00};
    vecs[4] = '{draw_board(), 43, DRAW_RES};
    vecs[5] = '{put(put(put(put(put(put(put(put(b, 0, 0, 2'b10), 0, 1, 2'b10), 0, 2, 2'b10), 0, 3, 2'b10),
                 1, 0, 2'b01), 1, 1, 2'b01), 1, 2, 2'b01), 1, 3, 2'b01), 2, 2'b10};
    vecs[6] = '{put(put(put(put(b, 0, 0, 2'b11), 0, 1, 2'b11), 0, 2, 2'b11), 0, 3, 2'b11), 43, 2'b00};
    vecs[7] = '{put(put(put(put(b, 1, 2, 2'b10), 2, 3, 2'b10), 3, 4, 2'b10), 4, 5, 2'b10), 11, 2'b10};
    vecs[8] = '{put(put(put(put(b, 5, 3, 2'b01), 5, 4, 2'b01), 5, 5, 2'b01), 5, 6, 2'b01), 40, 2'b01};
    vecs[9] = '{b, 43, 2'b00};
    vecs[10] = '{put(draw_board(), 3, 3, 2'b11), 43, 2'b00};

    rst_n = 1'b0;
    start = 1'b0;
    board = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ganador", int'(ganador), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].b, vecs[i].lat, vecs[i].gan);
      drain();
    end

    // Start pulse and board change mid-scan must be ignored; result comes from the snapshot.
    launch(vecs[0].b, vecs[0].lat, vecs[0].gan);
    drain();
    launch(draw_board(), 43, DRAW_RES);
    t = cyc - 1;
    while (cyc < t + 5) @(posedge clk);
    #1;
    board = vecs[0].b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset mid-scan aborts the scan with no trailing done.
    launch(vecs[0].b, vecs[0].lat, vecs[0].gan);
    drain();
    launch(vecs[9].b, 43, 2'b00);
    t = cyc - 1;
    while (cyc < t + 10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_ganador", int'(ganador), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    launch(vecs[2].b, vecs[2].lat, vecs[2].gan);
    drain();
    launch(vecs[1].b, vecs[1].lat, vecs[1].gan);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
